seletor_modo: RTL and testbench

//  Day/night mode selector; directly upstream of the traffic-light controller; drives its 'modo' input.

---
 rtl/semaforo_pkg.sv | 14 +
 rtl/sincronizador.sv | 20 ++
 rtl/seletor_modo.sv | 112 +++++++++++
 tb/tb_seletor_modo.sv | 130 +++++++++++++
 4 files changed

// File: rtl/semaforo_pkg.sv
// Shared types for the day/night mode selector that feeds the traffic-light controller.
package semaforo_pkg;

  typedef enum logic [1:0] {
    S_DIA        = 2'd0,
    S_CONF_NOITE = 2'd1,
    S_NOITE      = 2'd2,
    S_CONF_DIA   = 2'd3
  } estado_modo_e;

  localparam logic MODO_DIA   = 1'b0;
  localparam logic MODO_NOITE = 1'b1;

endpackage

// File: rtl/sincronizador.sv
// Multi-flop synchroniser for an asynchronous single-bit input; clears to 0 on reset.
module sincronizador #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ff <= '0;
    else       ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/seletor_modo.sv
// Day/night selector: synchronised, debounced dark sensor with minimum dwell per mode and
// manual overrides; all outputs registered so the controller sees a glitch-free 'modo'.
module seletor_modo
  import semaforo_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CICLOS  = 8,
  parameter int MIN_PERM    = 16,
  parameter int CW          = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor_escuro,
  input  logic forca_dia,
  input  logic forca_noite,
  output logic modo,
  output logic em_transicao,
  output logic troca
);

  localparam logic [CW-1:0] DEB_MAX  = CW'(DEB_CICLOS);
  localparam logic [CW-1:0] PERM_MAX = CW'(MIN_PERM);
  localparam logic [CW-1:0] UM       = CW'(1);

  logic          s_sync;
  estado_modo_e  estado, estado_nx;
  logic [CW-1:0] deb, deb_nx, perm, perm_nx;
  logic          modo_nx, em_nx;
  logic          ov_noite, ov_dia;

  sincronizador #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (sensor_escuro),
    .q     (s_sync)
  );

  // Conflicting overrides cancel each other and leave the FSM in automatic mode.
  assign ov_noite = forca_noite & ~forca_dia;
  assign ov_dia   = forca_dia & ~forca_noite;

  always_comb begin
    estado_nx = estado;
    deb_nx    = deb;
    if (ov_noite) begin
      estado_nx = S_NOITE;
      deb_nx    = '0;
    end else if (ov_dia) begin
      estado_nx = S_DIA;
      deb_nx    = '0;
    end else begin
      case (estado)
        S_DIA: if (s_sync && perm == PERM_MAX) begin
          estado_nx = S_CONF_NOITE;
          deb_nx    = UM;
        end
        S_CONF_NOITE: begin
          if (!s_sync) begin
            estado_nx = S_DIA;
            deb_nx    = '0;
          end else if (deb >= DEB_MAX) begin
            estado_nx = S_NOITE;
            deb_nx    = '0;
          end else deb_nx = deb + UM;
        end
        S_NOITE: if (!s_sync && perm == PERM_MAX) begin
          estado_nx = S_CONF_DIA;
          deb_nx    = UM;
        end
        S_CONF_DIA: begin
          if (s_sync) begin
            estado_nx = S_NOITE;
            deb_nx    = '0;
          end else if (deb >= DEB_MAX) begin
            estado_nx = S_DIA;
            deb_nx    = '0;
          end else deb_nx = deb + UM;
        end
        default: begin
          estado_nx = S_DIA;
          deb_nx    = '0;
        end
      endcase
    end

    // modo only flips once a confirmation completes (or an override lands).
    modo_nx = (estado_nx == S_NOITE || estado_nx == S_CONF_DIA) ? MODO_NOITE : MODO_DIA;
    em_nx   = (estado_nx == S_CONF_NOITE || estado_nx == S_CONF_DIA);
    if (modo_nx != modo)       perm_nx = '0;
    else if (perm == PERM_MAX) perm_nx = perm;
    else                       perm_nx = perm + UM;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado       <= S_DIA;
      deb          <= '0;
      perm         <= '0;
      modo         <= MODO_DIA;
      em_transicao <= 1'b0;
      troca        <= 1'b0;
    end else begin
      estado       <= estado_nx;
      deb          <= deb_nx;
      perm         <= perm_nx;
      modo         <= modo_nx;
      em_transicao <= em_nx;
      troca        <= (modo_nx != modo);
    end
  end

endmodule

// File: tb/tb_seletor_modo.sv
// Directed bench for seletor_modo with default parameters; expectations are hand-derived edge counts.
module tb_seletor_modo;

  logic clk = 1'b0;
  logic reset, sensor_escuro, forca_dia, forca_noite;
  logic modo, em_transicao, troca;
  int   errs  = 0;
  int   total = 0;

  always #5 clk = ~clk;

  seletor_modo dut (
    .clk           (clk),
    .reset         (reset),
    .sensor_escuro (sensor_escuro),
    .forca_dia     (forca_dia),
    .forca_noite   (forca_noite),
    .modo          (modo),
    .em_transicao  (em_transicao),
    .troca         (troca)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic outs(input string tag, input logic m, input logic e, input logic t);
    chk({tag, ".modo"}, 32'(modo), 32'(m));
    chk({tag, ".em"},   32'(em_transicao), 32'(e));
    chk({tag, ".troca"}, 32'(troca), 32'(t));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sensor held dark from reset release: perm saturates at edge 16, CONF at 17, night at 25.
  task automatic seq_reset(input string tag);
    for (int e = 1; e <= 26; e++) begin
      tick();
      outs($sformatf("%s.e%0d", tag, e), e >= 25, (e >= 17 && e <= 24), e == 25);
    end
  endtask

  initial begin
    reset = 1'b1; sensor_escuro = 1'b1; forca_dia = 1'b0; forca_noite = 1'b0;

    // 1: reset values, then power-up into night
    tick(); tick();
    outs("t1.rst", 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    seq_reset("t1");

    // 4: night entered two edges ago (perm=1), sensor goes light; dwell holds modo=1
    sensor_escuro = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      tick();
      outs($sformatf("t4.k%0d", k), k <= 23, (k >= 16 && k <= 23), k == 24);
    end

    // let perm saturate in day
    for (int k = 1; k <= 20; k++) begin
      tick();
      outs($sformatf("t4.dia%0d", k), 1'b0, 1'b0, 1'b0);
    end

    // 3: short dark glitch enters CONF and is aborted
    sensor_escuro = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      tick();
      outs($sformatf("t3.j%0d", j), 1'b0, (j >= 3 && j <= 7), 1'b0);
      if (j == 5) sensor_escuro = 1'b0;
    end

    // 2: perm saturated, steady dark -> modo on 11th edge
    sensor_escuro = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      tick();
      outs($sformatf("t2.j%0d", j), j >= 11, (j >= 3 && j <= 10), j == 11);
    end

    // 5: forca_dia in night with sensor dark, held
    forca_dia = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      tick();
      outs($sformatf("t5.fd%0d", j), 1'b0, 1'b0, j == 1);
    end
    forca_dia = 1'b0;
    forca_noite = 1'b1;
    tick();
    outs("t5.fn", 1'b1, 1'b0, 1'b1);
    forca_noite = 1'b0;
    tick();
    outs("t5.fn_rel", 1'b1, 1'b0, 1'b0);
    forca_dia = 1'b1; forca_noite = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      tick();
      outs($sformatf("t5.both%0d", j), 1'b1, 1'b0, 1'b0);
    end
    forca_dia = 1'b0;
    tick();
    outs("t5.fn_same", 1'b1, 1'b0, 1'b0);
    forca_noite = 1'b0;

    // 6: back to day, walk into CONF_NOITE mid-count, then async reset
    forca_dia = 1'b1;
    tick();
    outs("t6.fd", 1'b0, 1'b0, 1'b1);
    forca_dia = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      outs($sformatf("t6.i%0d", i), 1'b0, i >= 17, 1'b0);
    end
    #3 reset = 1'b1;
    #1 outs("t6.async", 1'b0, 1'b0, 1'b0);
    tick(); tick();
    outs("t6.held", 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    seq_reset("t6");

    $display("Result: errors=%0d of %0d checks", errs, total);
    $finish;
  end

endmodule
